// File: rtl/mips_seq_controller_if.sv
// Datapath-facing bundle of the MIPS sequencing controller: run control in,
// decoded datapath controls and status out.
interface mips_seq_controller_if;
  logic        start;
  logic        step;
  logic        resume;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        ALUZero;

  logic        PCinit;
  logic        pc_en;
  logic        RegWrite;
  logic        RegDst;
  logic        WRsel;
  logic        WDsel;
  logic        ALUsrc;
  logic        PCsrc;
  logic        jsel;
  logic        jrsel;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic [2:0]  ALUoperation;
  logic        halted;
  logic        illegal;
  logic [31:0] instr_count;

  modport slave (
    input  start, step, resume, opcode, func, ALUZero,
    output PCinit, pc_en, RegWrite, RegDst, WRsel, WDsel, ALUsrc, PCsrc,
           jsel, jrsel, MemRead, MemWrite, MemtoReg, ALUoperation,
           halted, illegal, instr_count
  );

  modport master (
    output start, step, resume, opcode, func, ALUZero,
    input  PCinit, pc_en, RegWrite, RegDst, WRsel, WDsel, ALUsrc, PCsrc,
           jsel, jrsel, MemRead, MemWrite, MemtoReg, ALUoperation,
           halted, illegal, instr_count
  );
endinterface

// File: rtl/mips_seq_controller.sv
// Single-cycle MIPS controller with IDLE/RUN/STEP/HALTED sequencing and a sticky illegal flag.
// Optional retired-instruction counter is built only when CTRL_PERF_CNT_EN is defined.
module mips_seq_controller (
  input  logic                  clk,
  input  logic                  rst,
  mips_seq_controller_if.slave  bus
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned ALU_W = 3;
  localparam int unsigned CNT_W = 32;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

  localparam logic [OP_W-1:0] FN_JR  = 6'b001000;
  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  typedef struct packed {
    logic             reg_write;
    logic             reg_dst;
    logic             wr_sel;
    logic             wd_sel;
    logic             alu_src;
    logic             pc_src;
    logic             jsel;
    logic             jr_sel;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic [ALU_W-1:0] alu_op;
  } ctl_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_illegal;
  logic   w_illegal_nxt;
  ctl_t   w_dec;
  ctl_t   w_ctl;
  logic   w_dec_legal;
  logic   w_dec_halt;
  logic   w_retire;
  logic   w_pcinit;
  logic   w_pc_en;

  // Instruction decode, purely combinational from opcode/func
  always_comb begin
    w_dec       = '0;
    w_dec_legal = 1'b1;
    w_dec_halt  = 1'b0;
    case (bus.opcode)
      OP_RTYPE: begin
        w_dec.reg_dst   = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.wd_sel    = 1'b1;
        case (bus.func)
          FN_ADD: w_dec.alu_op = ALU_ADD;
          FN_SUB: w_dec.alu_op = ALU_SUB;
          FN_AND: w_dec.alu_op = ALU_AND;
          FN_OR:  w_dec.alu_op = ALU_OR;
          FN_SLT: w_dec.alu_op = ALU_SLT;
          FN_JR: begin
            w_dec        = '0;
            w_dec.jr_sel = 1'b1;
          end
          default: begin
            w_dec       = '0;
            w_dec_legal = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        w_dec.alu_src    = 1'b1;
        w_dec.mem_read   = 1'b1;
        w_dec.mem_to_reg = 1'b1;
        w_dec.reg_write  = 1'b1;
        w_dec.wd_sel     = 1'b1;
        w_dec.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        w_dec.alu_src   = 1'b1;
        w_dec.mem_write = 1'b1;
        w_dec.alu_op    = ALU_ADD;
      end
      OP_ADDI, OP_SLTI: begin
        w_dec.alu_src   = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.wd_sel    = 1'b1;
        w_dec.alu_op    = (bus.opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      OP_BEQ: begin
        w_dec.alu_op = ALU_SUB;
        w_dec.pc_src = bus.ALUZero;
      end
      OP_J: w_dec.jsel = 1'b1;
      OP_JAL: begin
        w_dec.jsel      = 1'b1;
        w_dec.wr_sel    = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      OP_HALT: w_dec_halt = 1'b1;
      default: w_dec_legal = 1'b0;
    endcase
  end

  assign w_retire = ((r_state == S_RUN) || (r_state == S_STEP)) && w_dec_legal && !w_dec_halt;

  // State and sticky illegal flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  // Next state and gated datapath controls; only a retiring instruction drives strobes
  always_comb begin
    w_state_nxt   = r_state;
    w_illegal_nxt = r_illegal;
    w_ctl         = '0;
    w_pcinit      = 1'b0;
    w_pc_en       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pcinit = 1'b1;
        if (bus.start) w_state_nxt = S_RUN;
      end
      S_RUN, S_STEP: begin
        if (w_retire) begin
          w_ctl   = w_dec;
          w_pc_en = 1'b1;
          if (r_state == S_STEP) w_state_nxt = S_HALTED;
        end else begin
          w_state_nxt = S_HALTED;
          if (!w_dec_legal) w_illegal_nxt = 1'b1;
        end
      end
      S_HALTED: begin
        if (bus.resume)    w_state_nxt = S_RUN;
        else if (bus.step) w_state_nxt = S_STEP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.PCinit       = w_pcinit;
  assign bus.pc_en        = w_pc_en;
  assign bus.RegWrite     = w_ctl.reg_write;
  assign bus.RegDst       = w_ctl.reg_dst;
  assign bus.WRsel        = w_ctl.wr_sel;
  assign bus.WDsel        = w_ctl.wd_sel;
  assign bus.ALUsrc       = w_ctl.alu_src;
  assign bus.PCsrc        = w_ctl.pc_src;
  assign bus.jsel         = w_ctl.jsel;
  assign bus.jrsel        = w_ctl.jr_sel;
  assign bus.MemRead      = w_ctl.mem_read;
  assign bus.MemWrite     = w_ctl.mem_write;
  assign bus.MemtoReg     = w_ctl.mem_to_reg;
  assign bus.ALUoperation = w_ctl.alu_op;
  assign bus.halted       = (r_state == S_HALTED);
  assign bus.illegal      = r_illegal;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_instr_count;

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (!rst)          r_instr_count <= '0;
    else if (w_retire) r_instr_count <= r_instr_count + CNT_W'(1);
  end

  assign bus.instr_count = r_instr_count;
`else
  assign bus.instr_count = '0;
`endif

endmodule

// File: tb/tb_mips_seq_controller.sv
// Bench for mips_seq_controller: decode table in RUN plus hand-built sequencing cases.
module tb_mips_seq_controller;

  localparam logic [15:0] C_IDLE = 16'b1000000000000_000;
  localparam logic [15:0] C_NONE = 16'b0000000000000_000;
  localparam logic [15:0] C_ADD  = 16'b0111010000000_010;
  localparam logic [5:0]  OP_R    = 6'b000000;
  localparam logic [5:0]  F_ADD   = 6'b100000;
  localparam logic [5:0]  OP_HALT = 6'b111111;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [12:0] ctl;
    logic [2:0]  alu;
  } vec_t;

  typedef struct packed {
    logic [15:0] ctl;
    logic        halt;
  } exp_t;

  logic   clk;
  logic   rst;
  int     n_checks;
  int     n_fail;
  int     exp_cnt;
  vec_t   tbl [15];
  exp_t   sbq [$];

  mips_seq_controller_if bus_if ();

  mips_seq_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] act_ctl();
    return {bus_if.PCinit, bus_if.pc_en, bus_if.RegWrite, bus_if.RegDst, bus_if.WRsel,
            bus_if.WDsel, bus_if.ALUsrc, bus_if.PCsrc, bus_if.jsel, bus_if.jrsel,
            bus_if.MemRead, bus_if.MemWrite, bus_if.MemtoReg, bus_if.ALUoperation};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_cnt(input string nm);
`ifdef CTRL_PERF_CNT_EN
    chk(nm, bus_if.instr_count, 32'(exp_cnt));
`else
    chk(nm, bus_if.instr_count, 32'h0);
`endif
  endtask

  // One cycle: drive after the edge, queue the expectation, compare on the falling edge
  task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic st, input logic stp, input logic res, input logic rs,
                       input logic [15:0] ectl, input logic ehalt, input logic ret,
                       input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    bus_if.opcode  = op;
    bus_if.func    = fn;
    bus_if.ALUZero = z;
    bus_if.start   = st;
    bus_if.step    = stp;
    bus_if.resume  = res;
    rst            = rs;
    sbq.push_back('{ctl: ectl, halt: ehalt});
    @(negedge clk);
    e = sbq.pop_front();
    chk({nm, " ctl"}, 32'(act_ctl()), 32'(e.ctl));
    chk({nm, " halted"}, 32'(bus_if.halted), 32'(e.halt));
    if (ret) exp_cnt++;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 0;

    tbl[0]  = '{6'b000000, 6'b100000, 1'b0, 13'b0111010000000, 3'b010};
    tbl[1]  = '{6'b000000, 6'b100010, 1'b0, 13'b0111010000000, 3'b110};
    tbl[2]  = '{6'b000000, 6'b100100, 1'b0, 13'b0111010000000, 3'b000};
    tbl[3]  = '{6'b000000, 6'b100101, 1'b0, 13'b0111010000000, 3'b001};
    tbl[4]  = '{6'b000000, 6'b101010, 1'b0, 13'b0111010000000, 3'b111};
    tbl[5]  = '{6'b000000, 6'b001000, 1'b0, 13'b0100000001000, 3'b000};
    tbl[6]  = '{6'b100011, 6'b010101, 1'b0, 13'b0110011000101, 3'b010};
    tbl[7]  = '{6'b101011, 6'b111111, 1'b0, 13'b0100001000010, 3'b010};
    tbl[8]  = '{6'b001000, 6'b100010, 1'b0, 13'b0110011000000, 3'b010};
    tbl[9]  = '{6'b001010, 6'b000000, 1'b0, 13'b0110011000000, 3'b111};
    tbl[10] = '{6'b000100, 6'b000000, 1'b1, 13'b0100000100000, 3'b110};
    tbl[11] = '{6'b000100, 6'b000000, 1'b0, 13'b0100000000000, 3'b110};
    tbl[12] = '{6'b000010, 6'b000000, 1'b0, 13'b0100000010000, 3'b000};
    tbl[13] = '{6'b000011, 6'b000000, 1'b0, 13'b0110100010000, 3'b000};
    tbl[14] = '{6'b000000, 6'b100000, 1'b1, 13'b0111010000000, 3'b010};

    rst            = 1'b0;
    bus_if.start   = 1'b0;
    bus_if.step    = 1'b0;
    bus_if.resume  = 1'b0;
    bus_if.opcode  = OP_R;
    bus_if.func    = F_ADD;
    bus_if.ALUZero = 1'b0;
    repeat (2) @(posedge clk);

    // Reset into IDLE, then start
    apply(OP_R, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_IDLE, 1'b0, 1'b0, "reset idle");
    chk("reset illegal", 32'(bus_if.illegal), 32'h0);
    chk_cnt("reset count");
    apply(OP_R, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_IDLE, 1'b0, 1'b0, "idle no start");
    apply(OP_R, F_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, C_IDLE, 1'b0, 1'b0, "start seen");
    apply(OP_R, F_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, C_ADD,  1'b0, 1'b1, "first run");

    for (int i = 0; i < 15; i++)
      apply(tbl[i].op, tbl[i].fn, tbl[i].z, 1'b0, 1'b0, 1'b0, 1'b1,
            {tbl[i].ctl, tbl[i].alu}, 1'b0, 1'b1, $sformatf("tbl[%0d]", i));

    // HALT in RUN
    apply(OP_HALT, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 1'b0, "halt run");
    apply(OP_R, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NONE, 1'b1, 1'b0, "halted");
    chk_cnt("count after run");

    // Single step of ADD, then a step onto HALT
    apply(OP_R, F_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_NONE, 1'b1, 1'b0, "step pulse");
    apply(OP_R, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_ADD,  1'b0, 1'b1, "step exec");
    apply(OP_R, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NONE, 1'b1, 1'b0, "step done");
    apply(OP_HALT, 6'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_NONE, 1'b1, 1'b0, "step2 pulse");
    apply(OP_HALT, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 1'b0, "step halt");
    apply(OP_R, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NONE, 1'b1, 1'b0, "step2 done");
    chk_cnt("count after step");

    // resume wins over step
    apply(OP_R, F_ADD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, C_NONE, 1'b1, 1'b0, "res+step");
    apply(OP_R, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_ADD,  1'b0, 1'b1, "resumed");
    apply(OP_R, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_ADD,  1'b0, 1'b1, "still run");

    // Illegal opcode, sticky through resume
    apply(6'b010101, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 1'b0, "illegal op");
    apply(OP_R, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NONE, 1'b1, 1'b0, "illegal halted");
    chk("illegal set", 32'(bus_if.illegal), 32'h1);
    chk_cnt("count after illegal");
    apply(OP_R, F_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_NONE, 1'b1, 1'b0, "resume pulse");
    apply(OP_R, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_ADD,  1'b0, 1'b1, "resume run");
    chk("illegal sticky", 32'(bus_if.illegal), 32'h1);
    apply(OP_R, 6'b111111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 1'b0, "illegal func");
    apply(OP_R, F_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, C_NONE, 1'b1, 1'b0, "start ignored");
    chk("illegal held", 32'(bus_if.illegal), 32'h1);
    chk_cnt("count held");

    // Reset in the middle of STEP
    apply(OP_R, F_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_NONE, 1'b1, 1'b0, "step pulse2");
    apply(OP_R, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_ADD,  1'b0, 1'b0, "step rst");
    exp_cnt = 0;
    apply(OP_R, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_IDLE, 1'b0, 1'b0, "after rst");
    chk("illegal cleared", 32'(bus_if.illegal), 32'h0);
    chk_cnt("count cleared");

`ifdef CTRL_PERF_CNT_EN
    // Counter wrap from a preset value
    apply(OP_R, F_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, C_IDLE, 1'b0, 1'b0, "wrap start");
    force dut.r_instr_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_instr_count;
    apply(OP_R, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_ADD, 1'b0, 1'b0, "wrap run1");
    apply(OP_R, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_ADD, 1'b0, 1'b0, "wrap run2");
    chk("count max", bus_if.instr_count, 32'hFFFF_FFFF);
    apply(OP_HALT, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 1'b0, "wrap halt");
    chk("count wrapped", bus_if.instr_count, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
